// File: rtl/uart_tx.sv
// uart_tx: byte FIFO feeding an 8N1 serialiser (1 start, 8 data LSB first, 1 stop).
// The line idles high and every bit is held for exactly DIVISOR clocks.
module uart_tx #(
    parameter int unsigned CLOCK_RATE = 10000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    // Rounded clocks-per-bit so the bit period error stays within half a clock.
    localparam int unsigned DIVISOR = (CLOCK_RATE + BAUD_RATE / 2) / BAUD_RATE;
    localparam int unsigned BaudW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW  = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    state_t             state_q;
    logic [BaudW-1:0]   baud_cnt_q;
    logic [2:0]         bit_idx_q;
    logic [7:0]         shift_q;
    logic               tx_q;

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]    wr_ptr_q;
    logic [PtrW-1:0]    rd_ptr_q;
    logic [CountW-1:0]  count_q;

    logic               full;
    logic               not_empty;
    logic               baud_last;
    logic               push;
    logic               pop;
    logic [7:0]         head;

    // FIFO status, handshake and pop decision; pop only looks at registered state,
    // so a byte pushed into an empty FIFO cannot leave it in the same cycle.
    always_comb begin
        full      = (count_q == CountW'(FIFO_DEPTH));
        not_empty = (count_q != '0);
        baud_last = (baud_cnt_q == BaudW'(DIVISOR - 1));
        tx_ready  = !full;
        push      = tx_valid && !full;
        pop       = not_empty && ((state_q == StIdle) || ((state_q == StStop) && baud_last));
        head      = mem_q[rd_ptr_q];
        tx        = tx_q;
        busy      = (state_q != StIdle) || not_empty;
        fifo_count = count_q;
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CountW'(1);
                2'b01:   count_q <= count_q - CountW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Frame sequencer with a registered line output; a pop at the end of STOP
    // starts the next frame with no idle gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    tx_q       <= 1'b1;
                    baud_cnt_q <= '0;
                    if (not_empty) begin
                        shift_q <= head;
                        tx_q    <= 1'b0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (baud_last) begin
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        tx_q       <= shift_q[0];
                        state_q    <= StData;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BaudW'(1);
                    end
                end
                StData: begin
                    if (baud_last) begin
                        baud_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            // Present the next bit now, then retire the current one.
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BaudW'(1);
                    end
                end
                StStop: begin
                    if (baud_last) begin
                        baud_cnt_q <= '0;
                        if (not_empty) begin
                            shift_q <= head;
                            tx_q    <= 1'b0;
                            state_q <= StStart;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= StIdle;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BaudW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed scenarios for the 8N1 transmitter at 87 clocks per bit.
module tb_uart_tx;

    localparam int Div = 87;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int tests_run;
    int tests_failed;

    uart_tx #(
        .CLOCK_RATE (10000000),
        .BAUD_RATE  (115200),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst      = 1'b1;
        tx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        @(negedge clk);
        tests_run++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0 || tx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_asserted: got tx=%b busy=%b count=%0d ready=%b, want 1 0 0 1",
                     tx, busy, fifo_count, tx_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0 || tx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_released: got tx=%b busy=%b count=%0d ready=%b, want 1 0 0 1",
                     tx, busy, fifo_count, tx_ready);
        end
    endtask

    task automatic test_single_byte();
        logic [9:0] frame;
        frame = {1'b1, 8'hA5, 1'b0};
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        @(negedge clk);
        tx_valid = 1'b0;
        // Byte is queued but the start bit has not been driven yet.
        tests_run++;
        if (fifo_count !== 3'd1 || tx !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_latency: got count=%0d tx=%b busy=%b, want 1 1 1",
                     fifo_count, tx, busy);
        end
        for (int i = 0; i < 10 * Div; i++) begin
            @(negedge clk);
            tests_run++;
            if (tx !== frame[i / Div] || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL single_frame[%0d]: got tx=%b busy=%b, want tx=%b busy=1",
                         i, tx, busy, frame[i / Div]);
            end
        end
        @(negedge clk);
        tests_run++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL single_end: got tx=%b busy=%b count=%0d, want 1 0 0",
                     tx, busy, fifo_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] frames;
        frames = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        @(negedge clk);
        tx_data  = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
        tests_run++;
        if (fifo_count !== 3'd1 || tx !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_queued: got count=%0d tx=%b, want 1 0", fifo_count, tx);
        end
        for (int i = 1; i < 20 * Div; i++) begin
            @(negedge clk);
            tests_run++;
            if (tx !== frames[i / Div] || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_frame[%0d]: got tx=%b busy=%b, want tx=%b busy=1",
                         i, tx, busy, frames[i / Div]);
            end
        end
        @(negedge clk);
        tests_run++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_end: got tx=%b busy=%b, want 1 0", tx, busy);
        end
    endtask

    task automatic test_backpressure();
        int accepted;
        int waited;
        accepted = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h10;
        for (int c = 0; c < 20; c++) begin
            if (!tx_ready) break;
            accepted++;
            @(negedge clk);
            tx_data = tx_data + 8'd1;
        end
        tests_run++;
        if (accepted !== 5 || fifo_count !== 3'd4) begin
            tests_failed++;
            $display("FAIL bp_accepted: got accepted=%0d count=%0d, want 5 4",
                     accepted, fifo_count);
        end
        waited = 0;
        while (!tx_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        // The second pop lands at the end of the first frame.
        tests_run++;
        if (waited !== 867 || fifo_count !== 3'd3) begin
            tests_failed++;
            $display("FAIL bp_ready_return: got waited=%0d count=%0d, want 867 3",
                     waited, fifo_count);
        end
        @(negedge clk);
        tests_run++;
        if (tx_ready !== 1'b0 || fifo_count !== 3'd4) begin
            tests_failed++;
            $display("FAIL bp_refill: got ready=%b count=%0d, want 0 4", tx_ready, fifo_count);
        end
        repeat (1741 - 873) @(negedge clk);
        tests_run++;
        if (tx_ready !== 1'b0 || fifo_count !== 3'd4) begin
            tests_failed++;
            $display("FAIL bp_full_pre_pop: got ready=%b count=%0d, want 0 4",
                     tx_ready, fifo_count);
        end
        // Pop while full with tx_valid held: the push must be rejected.
        @(negedge clk);
        tests_run++;
        if (tx_ready !== 1'b1 || fifo_count !== 3'd3) begin
            tests_failed++;
            $display("FAIL bp_collision_full: got ready=%b count=%0d, want 1 3",
                     tx_ready, fifo_count);
        end
        tx_valid = 1'b0;
        apply_reset();
    endtask

    task automatic test_collision_count_two();
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h01;
        @(negedge clk);
        tx_data  = 8'h02;
        @(negedge clk);
        tx_data  = 8'h03;
        @(negedge clk);
        tx_valid = 1'b0;
        tests_run++;
        if (fifo_count !== 3'd2) begin
            tests_failed++;
            $display("FAIL c2_prefill: got count=%0d, want 2", fifo_count);
        end
        repeat (871 - 3) @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h04;
        tests_run++;
        if (fifo_count !== 3'd2 || tx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL c2_before: got count=%0d ready=%b, want 2 1", fifo_count, tx_ready);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        tests_run++;
        if (fifo_count !== 3'd2 || tx !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL c2_after: got count=%0d tx=%b busy=%b, want 2 0 1",
                     fifo_count, tx, busy);
        end
        apply_reset();
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] frame;
        frame = {1'b1, 8'h3C, 1'b0};
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        @(negedge clk);
        tx_data  = 8'hAA;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (398) @(negedge clk);
        // Inside data bit 3 with one byte still queued.
        tests_run++;
        if (tx !== frame[4] || busy !== 1'b1 || fifo_count !== 3'd1) begin
            tests_failed++;
            $display("FAIL rmf_before: got tx=%b busy=%b count=%0d, want %b 1 1",
                     tx, busy, fifo_count, frame[4]);
        end
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0 || tx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rmf_reset: got tx=%b busy=%b count=%0d ready=%b, want 1 0 0 1",
                     tx, busy, fifo_count, tx_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        frame = {1'b1, 8'h81, 1'b0};
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h81;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int i = 0; i < 10 * Div; i++) begin
            @(negedge clk);
            tests_run++;
            if (tx !== frame[i / Div]) begin
                tests_failed++;
                $display("FAIL rmf_frame[%0d]: got tx=%b, want %b", i, tx, frame[i / Div]);
            end
        end
        @(negedge clk);
        tests_run++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmf_end: got tx=%b busy=%b, want 1 0", tx, busy);
        end
    endtask

    task automatic test_bit_timing();
        logic prev;
        int   last_edge;
        int   n_edges;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        @(negedge clk);
        tx_valid = 1'b0;
        prev      = tx;
        last_edge = 0;
        n_edges   = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            if (tx !== prev) begin
                if (n_edges > 0) begin
                    tests_run++;
                    if (cyc - last_edge !== Div) begin
                        tests_failed++;
                        $display("FAIL timing_interval[%0d]: got %0d cycles, want %0d",
                                 n_edges, cyc - last_edge, Div);
                    end
                end
                last_edge = cyc;
                n_edges++;
                prev = tx;
            end
        end
        tests_run++;
        if (n_edges !== 10 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL timing_edges: got edges=%0d busy=%b, want 10 0", n_edges, busy);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_backpressure();
        test_collision_count_two();
        test_reset_mid_frame();
        test_bit_timing();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
